jtag_cmd_loader: RTL

- Upstream feeder for the JTAG shift engine.
- Parses a host byte stream (valid/ready; UART or USB bridge side) into command packets.
- Fills the engine's instruction FIFO or data FIFO.
- Starts the engine with one `work` pulse plus `op`/`len`, then tracks `busy` until the transaction completes, and reports done or error.

---
 rtl/jtag_cmd_loader.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/jtag_cmd_loader.sv
// Host byte-stream packet parser that fills the JTAG engine's instruction/data FIFOs,
// then launches one engine transaction and reports its completion or failure.
module jtag_cmd_loader #(
  parameter int DATA_INSTRACTION = 10,
  parameter int DATA_FIFO        = 8,
  parameter int BUSY_TIMEOUT     = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic [15:0]                 len,
  output logic                        op,
  output logic                        work,
  input  logic                        busy,
  output logic [DATA_INSTRACTION-1:0] wdata_instraction,
  output logic                        wr_instraction,
  input  logic                        full_instraction,
  output logic [DATA_FIFO-1:0]        wdata_data,
  output logic                        wr_data,
  input  logic                        full_data,
  output logic                        done,
  output logic                        err,
  output logic [1:0]                  err_code,
  output logic [2:0]                  dbg_state
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LEN_HI    = 3'd1,
    ST_LEN_LO    = 3'd2,
    ST_PAYLOAD   = 3'd3,
    ST_START     = 3'd4,
    ST_WAIT_BUSY = 3'd5,
    ST_WAIT_DONE = 3'd6
  } state_t;

  state_t                      state_q;
  logic [15:0]                 len_q;
  logic                        op_q;
  logic                        work_q;
  logic [DATA_INSTRACTION-1:0] wdata_instraction_q;
  logic                        wr_instraction_q;
  logic [DATA_FIFO-1:0]        wdata_data_q;
  logic                        wr_data_q;
  logic                        done_q;
  logic                        err_q;
  logic [1:0]                  err_code_q;
  logic [12:0]                 cnt_q;
  logic [7:0]                  ibyte_q;
  logic [TW-1:0]               tmo_q;

  logic        ready_c;
  logic        take;
  logic [15:0] len_lo;
  logic        instr_len_ok;

  // Handshake: a byte moves on any rising clk where s_valid && s_ready; s_ready never
  // looks at s_valid, and the host must hold s_data stable while s_valid is high.
  always_comb begin
    ready_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_LEN_HI, ST_LEN_LO: ready_c = 1'b1;
      ST_PAYLOAD: begin
        if (op_q) ready_c = !full_data && !wr_data_q;
        else      ready_c = (cnt_q != 13'd0) || !full_instraction;
      end
      default: ready_c = 1'b0;
    endcase
  end

  assign take         = s_valid && ready_c;
  assign len_lo       = {len_q[15:8], s_data};
  assign instr_len_ok = (len_q != 16'd0) && (len_q <= 16'(DATA_INSTRACTION));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q             <= ST_IDLE;
      len_q               <= '0;
      op_q                <= 1'b0;
      work_q              <= 1'b0;
      wdata_instraction_q <= '0;
      wr_instraction_q    <= 1'b0;
      wdata_data_q        <= '0;
      wr_data_q           <= 1'b0;
      done_q              <= 1'b0;
      err_q               <= 1'b0;
      err_code_q          <= 2'd0;
      cnt_q               <= '0;
      ibyte_q             <= '0;
      tmo_q               <= '0;
    end else begin
      wr_instraction_q <= 1'b0;
      wr_data_q        <= 1'b0;
      work_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            if (s_data == 8'h01 || s_data == 8'h02) begin
              op_q    <= (s_data == 8'h02);
              state_q <= ST_LEN_HI;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'd1;
            end
          end
        end
        ST_LEN_HI: begin
          if (take) begin
            len_q[15:8] <= s_data;
            state_q     <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (take) begin
            len_q[7:0] <= s_data;
            if (op_q && len_lo == 16'd0) begin
              err_q      <= 1'b1;
              err_code_q <= 2'd2;
              state_q    <= ST_IDLE;
            end else begin
              // Count holds "bytes left minus one" so 8192 data bytes fit in 13 bits.
              cnt_q   <= op_q ? 13'((len_lo - 16'd1) >> 3) : 13'd1;
              state_q <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (take) begin
            if (op_q) begin
              wdata_data_q <= DATA_FIFO'(s_data);
              wr_data_q    <= 1'b1;
              if (cnt_q == 13'd0) state_q <= ST_START;
              else                cnt_q   <= cnt_q - 13'd1;
            end else if (cnt_q != 13'd0) begin
              ibyte_q <= s_data;
              cnt_q   <= cnt_q - 13'd1;
            end else if (instr_len_ok) begin
              wdata_instraction_q <= {s_data[DATA_INSTRACTION-9:0], ibyte_q};
              wr_instraction_q    <= 1'b1;
              state_q             <= ST_START;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= 2'd2;
              state_q    <= ST_IDLE;
            end
          end
        end
        ST_START: begin
          // The final FIFO strobe is high during this cycle; work follows it.
          work_q  <= 1'b1;
          tmo_q   <= '0;
          state_q <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
            err_q      <= 1'b1;
            err_code_q <= 2'd3;
            state_q    <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!busy) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready           = ready_c;
  assign len               = len_q;
  assign op                = op_q;
  assign work              = work_q;
  assign wdata_instraction = wdata_instraction_q;
  assign wr_instraction    = wr_instraction_q;
  assign wdata_data        = wdata_data_q;
  assign wr_data           = wr_data_q;
  assign done              = done_q;
  assign err               = err_q;
  assign err_code          = err_code_q;
  assign dbg_state         = state_q;

endmodule
